// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: the default digit
// count, the all-off cathode pattern and the hex-to-segment lookup table.
package seg_scan_ctrl_pkg;

    localparam int DEFAULT_NUM_DIGITS = 8;

    // Cathodes are active-low, so all ones turns every segment off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns; entry n lives at index n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner. A synchronised rising edge
// of led_clk advances the digit index; display data is snapshotted once per
// frame (when the scan wraps to digit 0) so a frame never mixes two values.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          led_clk,
    input  logic [4*NUM_DIGITS-1:0]       data_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         blank_in,
    input  logic                          lz_en,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic                          frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [SYNC_STAGES-1:0]  sync_reg;
    logic                    hist_reg;
    logic                    step;
    logic                    wrap;

    logic [IDX_W-1:0]        digit_sel_reg, digit_next;
    logic [4*NUM_DIGITS-1:0] data_reg, data_next;
    logic [NUM_DIGITS-1:0]   dp_shadow_reg, dp_shadow_next;
    logic [NUM_DIGITS-1:0]   blank_reg, blank_next;
    logic                    lz_reg, lz_next;

    logic [NUM_DIGITS-1:0]   an_reg, an_next;
    logic [6:0]              seg_reg, seg_next;
    logic                    dp_reg, dp_next;
    logic                    frame_done_reg;

    logic [3:0]              nibble_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   digit_blank;
    logic [6:0]              seg_dec;

    // Bring led_clk into the clk domain and remember the last synced level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], led_clk};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    // One-cycle pulse per synced rising edge; falling edges are ignored.
    assign step = sync_reg[SYNC_STAGES-1] & ~hist_reg;
    assign wrap = step && (digit_sel_reg == LAST_IDX);

    // Next digit index and next frame snapshot (refreshed only on wrap).
    always_comb begin
        digit_next     = digit_sel_reg;
        data_next      = data_reg;
        dp_shadow_next = dp_shadow_reg;
        blank_next     = blank_reg;
        lz_next        = lz_reg;
        if (step) begin
            digit_next = wrap ? '0 : digit_sel_reg + 1'b1;
        end
        if (wrap) begin
            data_next      = data_in;
            dp_shadow_next = dp_in;
            blank_next     = blank_in;
            lz_next        = lz_en;
        end
    end

    // Per-digit nibble split and leading-zero blanking of the upcoming snapshot.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign nibble_arr[gi] = data_next[4*gi +: 4];
        if (gi == 0) begin : g_rightmost
            // The rightmost digit always shows, so a zero value reads "0".
            assign lz_blank[gi] = 1'b0;
        end else begin : g_upper
            assign lz_blank[gi] = lz_next && (data_next[4*NUM_DIGITS-1:4*gi] == '0);
        end
    end

    assign digit_blank = blank_next | lz_blank;

    hex_to_seg u_hex_to_seg (
        .nibble (nibble_arr[digit_next]),
        .seg    (seg_dec)
    );

    // Pin values for the digit that will be active after this edge.
    always_comb begin
        an_next  = '1;
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        if (!digit_blank[digit_next]) begin
            an_next[digit_next] = 1'b0;
            seg_next            = seg_dec;
            dp_next             = ~dp_shadow_next[digit_next];
        end
    end

    // Scan state, snapshot and registered pin drive; everything holds without a step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_sel_reg  <= LAST_IDX;
            data_reg       <= '0;
            dp_shadow_reg  <= '0;
            blank_reg      <= '0;
            lz_reg         <= 1'b0;
            an_reg         <= '1;
            seg_reg        <= SEG_BLANK;
            dp_reg         <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            data_reg       <= data_next;
            dp_shadow_reg  <= dp_shadow_next;
            blank_reg      <= blank_next;
            lz_reg         <= lz_next;
            frame_done_reg <= wrap;
            if (step) begin
                digit_sel_reg <= digit_next;
                an_reg        <= an_next;
                seg_reg       <= seg_next;
                dp_reg        <= dp_next;
            end
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign digit_sel  = digit_sel_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus randomized frames checked
// against a per-digit model computed from the snapshot captured at each wrap.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        led_clk = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  blank_in = '0;
    logic        lz_en = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  digit_sel;
    logic        frame_done;

    int checks = 0;
    int passed = 0;

    seg_scan_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .led_clk    (led_clk),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Observed activity, sampled on the falling edge.
    int         fd_count = 0;
    int         sel_changes = 0;
    logic [2:0] prev_sel = 3'd7;
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
        if (digit_sel !== prev_sel) sel_changes++;
        prev_sel = digit_sel;
    end

    // Reference model: current digit and the snapshot taken at the last wrap.
    int          m_d = 7;
    logic [31:0] m_data = '0;
    logic [7:0]  m_dp = '0;
    logic [7:0]  m_blank = '0;
    logic        m_lz = 1'b0;
    logic [6:0]  hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic void expect_out(input int d, output logic [7:0] e_an,
                                       output logic [6:0] e_seg, output logic e_dp);
        logic blank;
        blank = m_blank[d] || (m_lz && d > 0 && (m_data >> (4*d)) == 32'd0);
        e_an  = blank ? 8'hFF : ~(8'h01 << d);
        e_seg = blank ? 7'h7F : hex_tbl[m_data[4*d +: 4]];
        e_dp  = blank ? 1'b1 : ~m_dp[d];
    endfunction

    function automatic void model_reset();
        m_d = 7; m_data = '0; m_dp = '0; m_blank = '0; m_lz = 1'b0;
    endfunction

    // One clean led_clk period; returns with outputs settled, model advanced.
    task automatic led_pulse();
        @(negedge clk) led_clk = 1'b1;
        repeat (4) @(negedge clk);
        led_clk = 1'b0;
        repeat (3) @(negedge clk);
        m_d = (m_d + 1) % 8;
        if (m_d == 0) begin
            m_data = data_in; m_dp = dp_in; m_blank = blank_in; m_lz = lz_en;
        end
    endtask

    task automatic goto_last();
        while (m_d != 7) led_pulse();
    endtask

    task automatic test_reset();
        int fd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (an !== 8'hFF) $display("FAIL reset_an got %h want FF", an); else passed++;
        checks++; if (seg !== 7'h7F) $display("FAIL reset_seg got %h want 7F", seg); else passed++;
        checks++; if (dp !== 1'b1) $display("FAIL reset_dp got %b want 1", dp); else passed++;
        checks++; if (digit_sel !== 3'd7) $display("FAIL reset_sel got %0d want 7", digit_sel); else passed++;
        checks++; if (frame_done !== 1'b0) $display("FAIL reset_fd got %b want 0", frame_done); else passed++;
        data_in = 32'h0123ABCD;
        repeat (4) led_pulse();
        checks++; if (digit_sel !== 3'd3) $display("FAIL pre_reset_sel got %0d want 3", digit_sel); else passed++;
        // Assert reset away from any clock edge; it must act immediately.
        @(posedge clk); #2 reset = 1'b0; #1;
        checks++; if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || digit_sel !== 3'd7)
            $display("FAIL midscan_reset got an=%h seg=%h dp=%b sel=%0d want FF 7F 1 7", an, seg, dp, digit_sel);
            else passed++;
        model_reset();
        @(negedge clk) reset = 1'b1;
        fd0 = fd_count;
        led_pulse();
        checks++; if (digit_sel !== 3'd0 || an !== 8'hFE || seg !== 7'h21)
            $display("FAIL post_reset_first got sel=%0d an=%h seg=%h want 0 FE 21", digit_sel, an, seg);
            else passed++;
        checks++; if (fd_count - fd0 != 1) $display("FAIL post_reset_fd got %0d want 1", fd_count - fd0); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_scan_sequence();
        logic [7:0] exp_an [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        logic [6:0] exp_seg [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h30, 7'h24, 7'h79, 7'h40};
        int fd0;
        data_in = 32'h0123ABCD; dp_in = '0; blank_in = '0; lz_en = 1'b0;
        goto_last();
        for (int i = 0; i < 8; i++) begin
            fd0 = fd_count;
            led_pulse();
            checks++; if (an !== exp_an[i] || seg !== exp_seg[i])
                $display("FAIL seq_digit%0d got an=%h seg=%h want %h %h", i, an, seg, exp_an[i], exp_seg[i]);
                else passed++;
            checks++; if (fd_count - fd0 != ((i == 0) ? 1 : 0))
                $display("FAIL seq_fd%0d got %0d pulses want %0d", i, fd_count - fd0, (i == 0) ? 1 : 0);
                else passed++;
        end
        $display("test_scan_sequence done");
    endtask

    task automatic test_leading_zero();
        logic [31:0] pats [2] = '{32'h000000A5, 32'h00000000};
        logic [7:0] e_an; logic [6:0] e_seg;
        lz_en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            data_in = pats[p];
            goto_last();
            for (int i = 0; i < 8; i++) begin
                led_pulse();
                e_an = 8'hFF; e_seg = 7'h7F;
                if (i == 0) begin e_an = 8'hFE; e_seg = (p == 0) ? 7'h12 : 7'h40; end
                if (i == 1 && p == 0) begin e_an = 8'hFD; e_seg = 7'h08; end
                checks++; if (an !== e_an || seg !== e_seg)
                    $display("FAIL lz_p%0d_digit%0d got an=%h seg=%h want %h %h", p, i, an, seg, e_an, e_seg);
                    else passed++;
            end
        end
        lz_en = 1'b0;
        $display("test_leading_zero done");
    endtask

    task automatic test_mid_frame();
        data_in = 32'h11111111;
        goto_last();
        repeat (5) led_pulse();
        data_in = 32'h22222222;
        for (int i = 5; i < 8; i++) begin
            led_pulse();
            checks++; if (seg !== 7'h79) $display("FAIL midframe_digit%0d got seg=%h want 79", i, seg); else passed++;
        end
        led_pulse();
        checks++; if (seg !== 7'h24 || an !== 8'hFE)
            $display("FAIL midframe_next0 got an=%h seg=%h want FE 24", an, seg); else passed++;
        $display("test_mid_frame done");
    endtask

    task automatic test_dp_blank();
        data_in = 32'h0123ABCD; dp_in = 8'h04; blank_in = 8'h80;
        goto_last();
        for (int i = 0; i < 8; i++) begin
            led_pulse();
            checks++; if (dp !== ((an === 8'hFB) ? 1'b0 : 1'b1))
                $display("FAIL dp_digit%0d got dp=%b an=%h want dp low only at FB", i, dp, an); else passed++;
            if (i == 7) begin
                checks++; if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1)
                    $display("FAIL blank_digit7 got an=%h seg=%h dp=%b want FF 7F 1", an, seg, dp); else passed++;
            end
        end
        dp_in = '0; blank_in = '0;
        $display("test_dp_blank done");
    endtask

    task automatic test_scan_random();
        logic [7:0] e_an; logic [6:0] e_seg; logic e_dp;
        int fd0;
        for (int n = 0; n < 48; n++) begin
            if (m_d == 7 || $urandom_range(0, 3) == 0) begin
                data_in  = $urandom >> $urandom_range(0, 31);
                dp_in    = 8'($urandom);
                blank_in = ($urandom_range(0, 1) == 1) ? (8'($urandom) & 8'($urandom)) : 8'h00;
                lz_en    = 1'($urandom_range(0, 1));
            end
            fd0 = fd_count;
            led_pulse();
            expect_out(m_d, e_an, e_seg, e_dp);
            checks++; if (digit_sel !== 3'(m_d) || an !== e_an || seg !== e_seg || dp !== e_dp)
                $display("FAIL rand%0d got sel=%0d an=%h seg=%h dp=%b want %0d %h %h %b",
                         n, digit_sel, an, seg, dp, m_d, e_an, e_seg, e_dp);
                else passed++;
            checks++; if (fd_count - fd0 != ((m_d == 0) ? 1 : 0))
                $display("FAIL rand_fd%0d got %0d pulses want %0d", n, fd_count - fd0, (m_d == 0) ? 1 : 0);
                else passed++;
        end
        $display("test_scan_random done");
    endtask

    task automatic test_step_latency();
        int rises = 0;
        int sc0;
        logic [2:0] sel0;
        logic [7:0] an0;
        data_in = 32'h0123ABCD; dp_in = '0; blank_in = '0; lz_en = 1'b0;
        // Random clean toggles: every rising edge must advance the index once.
        sc0 = sel_changes;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk) led_clk = ~led_clk;
            if (led_clk) rises++;
            repeat ($urandom_range(3, 9)) @(negedge clk);
        end
        led_clk = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (sel_changes - sc0 != rises)
            $display("FAIL step_count got %0d steps want %0d", sel_changes - sc0, rises); else passed++;
        // Stalled high: one step, then nothing for 1000 cycles.
        @(negedge clk) led_clk = 1'b1;
        repeat (4) @(negedge clk);
        sel0 = digit_sel; sc0 = sel_changes;
        repeat (1000) @(negedge clk);
        checks++; if (digit_sel !== sel0 || sel_changes != sc0)
            $display("FAIL hold_high got sel=%0d changes=%0d want %0d 0", digit_sel, sel_changes - sc0, sel0);
            else passed++;
        led_clk = 1'b0;
        repeat (4) @(negedge clk);
        // Latency: first sampling edge k, outputs move at edge k+2.
        sel0 = digit_sel; an0 = an;
        @(negedge clk) led_clk = 1'b1;
        @(negedge clk);
        checks++; if (digit_sel !== sel0) $display("FAIL latency_k got sel=%0d want %0d", digit_sel, sel0); else passed++;
        @(negedge clk);
        checks++; if (digit_sel !== sel0 || an !== an0)
            $display("FAIL latency_k1 got sel=%0d an=%h want %0d %h", digit_sel, an, sel0, an0); else passed++;
        @(negedge clk);
        checks++; if (digit_sel !== 3'(sel0 + 3'd1) || an === an0)
            $display("FAIL latency_k2 got sel=%0d an=%h want %0d and new an", digit_sel, an, 3'(sel0 + 3'd1));
            else passed++;
        led_clk = 1'b0;
        repeat (4) @(negedge clk);
        $display("test_step_latency done");
    endtask

    initial begin
        test_reset();
        test_scan_sequence();
        test_leading_zero();
        test_mid_frame();
        test_dp_blank();
        test_scan_random();
        test_step_latency();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
